// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester: default widths/timeout and the
// driver FSM state encodings.
package gcd_pkg;

    localparam int GCD_W       = 16;
    localparam int GCD_TIMEOUT = 200;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_ACK   = ST_ACK,
        S_RESP  = ST_RESP
    } drv_state_e;

endpackage

// File: rtl/gcd_timeout_ctr.sv
// Clear/enable counter that flags expiry once it has counted TIMEOUT-1 cycles.
// A TIMEOUT of 0 disables expiry entirely.
module gcd_timeout_ctr #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expire_o = 1'b0;
        end else begin : g_timeout
            assign expire_o = (count_q == TO_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/gcd_req_driver.sv
// Requester side of the GCD unit handshake: takes operand pairs from upstream,
// runs one GCD transaction at a time and returns the result (or a timeout error).
module gcd_req_driver
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = GCD_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    output logic [W-1:0]     gcd_operand_A,
    output logic [W-1:0]     gcd_operand_B,
    output logic             gcd_input_avail,
    input  logic             gcd_result_rdy,
    input  logic [W-1:0]     gcd_result_data,
    output logic             gcd_result_taken,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [W-1:0]     resp_data,
    output logic             resp_err,
    output logic [CNT_W-1:0] txn_count,
    output logic             busy
);

    drv_state_e       state_q, state_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic [W-1:0]     result_q, result_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timer_clr;
    logic             timer_en;
    logic             timer_expire;

    gcd_timeout_ctr #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (timer_clr),
        .en_i     (timer_en),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        result_d  = result_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_a_d  = req_a;
                    op_b_d  = req_b;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_clr = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle still wins.
                if (gcd_result_rdy) begin
                    result_d = gcd_result_data;
                    state_d  = S_ACK;
                end else if (timer_expire) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    timer_en = 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Every output is a pure decode of state/registers, so no input reaches
    // the GCD-side ports combinationally.
    assign req_ready        = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign gcd_input_avail  = (state_q == S_ISSUE);
    assign gcd_result_taken = (state_q == S_ACK);
    assign resp_valid       = (state_q == S_RESP);
    assign gcd_operand_A    = op_a_q;
    assign gcd_operand_B    = op_b_q;
    assign resp_data        = result_q;
    assign resp_err         = err_q;
    assign txn_count        = cnt_q;

endmodule

// File: tb/tb_gcd_req_driver.sv
// Directed bench for gcd_req_driver against a behavioural GCD unit with a
// fixed 3-cycle compute delay and an optional "hang" mode.
module tb_gcd_req_driver;

    localparam int W     = 16;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [W-1:0]     req_a;
    logic [W-1:0]     req_b;
    logic [W-1:0]     gcd_operand_A;
    logic [W-1:0]     gcd_operand_B;
    logic             gcd_input_avail;
    logic             gcd_result_rdy;
    logic [W-1:0]     gcd_result_data;
    logic             gcd_result_taken;
    logic             resp_valid;
    logic             resp_ready;
    logic [W-1:0]     resp_data;
    logic             resp_err;
    logic [CNT_W-1:0] txn_count;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int ia_cnt = 0;
    int tk_cnt = 0;
    logic hang = 1'b0;

    logic [W-1:0] m_a, m_b;
    logic         m_busy;
    int           m_delay;

    gcd_req_driver #(
        .W       (W),
        .TO_W    (8),
        .TIMEOUT (64),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .gcd_operand_A    (gcd_operand_A),
        .gcd_operand_B    (gcd_operand_B),
        .gcd_input_avail  (gcd_input_avail),
        .gcd_result_rdy   (gcd_result_rdy),
        .gcd_result_data  (gcd_result_data),
        .gcd_result_taken (gcd_result_taken),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_err         (resp_err),
        .txn_count        (txn_count),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = y;
            y = x % y;
            x = t;
        end
        return x;
    endfunction

    // Behavioural GCD unit and pulse counters, evaluated on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            gcd_result_rdy  = 1'b0;
            gcd_result_data = '0;
            m_busy          = 1'b0;
            m_delay         = 0;
        end else begin
            if (gcd_result_taken) gcd_result_rdy = 1'b0;
            if (gcd_input_avail) begin
                m_a     = gcd_operand_A;
                m_b     = gcd_operand_B;
                m_busy  = 1'b1;
                m_delay = 3;
            end else if (m_busy && !hang) begin
                if (m_delay == 0) begin
                    gcd_result_rdy  = 1'b1;
                    gcd_result_data = gcd_fn(m_a, m_b);
                    m_busy          = 1'b0;
                end else begin
                    m_delay = m_delay - 1;
                end
            end
            if (gcd_input_avail)  ia_cnt = ia_cnt + 1;
            if (gcd_result_taken) tk_cnt = tk_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction; exp_k = samples from ISSUE until resp_valid.
    task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_d, input logic exp_e, input int hold,
                           input int exp_k, input logic [CNT_W-1:0] exp_cnt);
        int k;
        int tk0;
        tk0 = tk_cnt;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 100) begin
            step();
            k++;
        end
        step();
        req_valid = 1'b0;
        chk({tag, "/issue"}, {15'd0, gcd_input_avail, gcd_operand_A}, {15'd0, 1'b1, a});
        chk({tag, "/op_b"}, {16'd0, gcd_operand_B}, {16'd0, b});
        k = 0;
        while (!resp_valid && k < 200) begin
            step();
            k++;
        end
        chk({tag, "/latency"}, k, exp_k);
        for (int h = 0; h < hold; h++) begin
            chk({tag, "/hold"}, {14'd0, resp_valid, req_ready, resp_data}, {14'd0, 1'b1, 1'b0, exp_d});
            step();
        end
        chk({tag, "/resp"}, {15'd0, resp_err, resp_data}, {15'd0, exp_e, exp_d});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, "/idle"}, {resp_valid, req_ready, busy}, 3'b010);
        chk({tag, "/taken"}, tk_cnt - tk0, exp_e ? 0 : 1);
        chk({tag, "/count"}, txn_count, exp_cnt);
        $display("txn %s a=%0d b=%0d -> data=%0d err=%0b count=%0d", tag, a, b, resp_data, resp_err, txn_count);
    endtask

    initial begin
        logic [W-1:0] pa [3];
        logic [W-1:0] pb [3];
        logic [W-1:0] pe [3];
        logic [W-1:0] got [3];
        int idx, nresp, ia0, tk0;
        logic fire;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (3) step();
        chk("reset/ctrl", {req_ready, busy, gcd_input_avail, gcd_result_taken, resp_valid, resp_err}, 6'b100000);
        chk("reset/ops", {gcd_operand_A, gcd_operand_B}, 32'd0);
        chk("reset/data_cnt", {resp_data, txn_count}, 32'd0);
        reset_n = 1'b1;
        step();

        run_txn("t27_15", 16'd27, 16'd15, 16'd3, 1'b0, 0, 6, 16'd1);
        run_txn("t15_27", 16'd15, 16'd27, 16'd3, 1'b0, 0, 6, 16'd2);
        run_txn("t100_75", 16'd100, 16'd75, 16'd25, 1'b0, 0, 6, 16'd3);
        run_txn("bp48_18", 16'd48, 16'd18, 16'd6, 1'b0, 5, 6, 16'd4);
        run_txn("zero_9", 16'd0, 16'd9, 16'd9, 1'b0, 0, 6, 16'd5);

        // Hung unit: 64 WAIT cycles then error response (65 samples after ISSUE).
        hang = 1'b1;
        run_txn("timeout", 16'd7, 16'd5, 16'd0, 1'b1, 0, 65, 16'd6);
        hang = 1'b0;
        step();

        // Reset in the middle of WAIT.
        hang = 1'b1;
        tk0 = tk_cnt;
        req_a = 16'd27;
        req_b = 16'd15;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("midrst/issue", gcd_input_avail, 1'b1);
        repeat (3) step();
        chk("midrst/in_wait", {busy, resp_valid}, 2'b10);
        reset_n = 1'b0;
        #1;
        chk("midrst/ctrl", {req_ready, busy, gcd_input_avail, gcd_result_taken, resp_valid, resp_err}, 6'b100000);
        chk("midrst/regs", {gcd_operand_A, txn_count}, 32'd0);
        step();
        reset_n = 1'b1;
        hang = 1'b0;
        step();
        chk("midrst/no_taken", tk_cnt - tk0, 0);
        run_txn("post_rst", 16'd27, 16'd15, 16'd3, 1'b0, 0, 6, 16'd1);

        // Three pairs back-to-back with req_valid held high.
        pa[0] = 16'd12; pb[0] = 16'd8;  pe[0] = 16'd4;
        pa[1] = 16'd81; pb[1] = 16'd27; pe[1] = 16'd27;
        pa[2] = 16'd17; pb[2] = 16'd5;  pe[2] = 16'd1;
        got[0] = '0; got[1] = '0; got[2] = '0;
        idx = 0;
        nresp = 0;
        ia0 = ia_cnt;
        req_a = pa[0];
        req_b = pb[0];
        req_valid = 1'b1;
        resp_ready = 1'b1;
        for (int c = 0; c < 300 && nresp < 3; c++) begin
            fire = req_valid && req_ready;
            if (resp_valid) begin
                got[nresp] = resp_data;
                $display("b2b resp %0d data=%0d count=%0d", nresp, resp_data, txn_count);
                nresp++;
            end
            step();
            if (fire) begin
                idx++;
                if (idx < 3) begin
                    req_a = pa[idx];
                    req_b = pb[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        resp_ready = 1'b0;
        req_valid = 1'b0;
        chk("b2b/nresp", nresp, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b/data%0d", i), got[i], pe[i]);
        end
        chk("b2b/avail_pulses", ia_cnt - ia0, 3);
        chk("b2b/count", txn_count, 16'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
